bias_add: RTL
=============

BIAS_ADD -- requirements
Module: bias_add

Interface
REQ-001 The block SHALL have parameter LANES, default 32, meaning number of 16-bit lanes per vector.
REQ-002 The block SHALL have parameter DW, default 16, meaning lane width in bits (signed two's complement).
REQ-003 The block SHALL have parameter BEATS, default 4, meaning bias-load beats per full bias vector (128 bits per beat).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 bias_load_en  input  1  one-cycle pulse requesting a new bias vector load.
REQ-007 bias_wr_valid  input  1  bias beat valid.
REQ-008 bias_wr_data  input  128  bias beat; beat k carries lanes 8k..8k+7, lane 8k in bits [15:0].
REQ-009 bias_loaded  output  1  high when a complete bias vector is held and the block is in RUN.
REQ-010 in_valid  input  1  partial-sum vector valid.
REQ-011 in_ready  output  1  block accepts in_data this cycle.
REQ-012 in_data  input  LANES*DW  32 signed partial sums, lane i in bits [(i+1)*16-1:i*16].
REQ-013 in_relu_en  input  1  ReLU enable travelling with the vector.
REQ-014 out_valid  output  1  bias_data valid.
REQ-015 out_ready  input  1  downstream (relu stage) accepts bias_data.
REQ-016 bias_data  output  LANES*DW  saturated sum vector, same lane packing as in_data.
REQ-017 calculate_en  output  1  in_relu_en delayed to align with bias_data.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RUN; reset enters IDLE.
REQ-019 IDLE -> LOAD on bias_load_en; RUN -> LOAD on bias_load_en only when both pipeline stages are empty, otherwise the request is ignored.
REQ-020 In LOAD each cycle with bias_wr_valid writes bias_wr_data into beat slot beat_cnt and increments beat_cnt; after beat BEATS-1 the FSM enters RUN and beat_cnt returns to 0.
REQ-021 bias_load_en asserted while in LOAD SHALL be ignored; beats arriving outside LOAD SHALL be ignored.
REQ-022 in_ready = (state==RUN) and not stall, where stall = out_valid and not out_ready.
REQ-023 Pipeline stage 1 SHALL register per-lane 17-bit sign-extended sum in_data[i]+bias[i] plus valid and relu_en on in_valid and in_ready.
REQ-024 Stage 2 SHALL register per-lane saturation: sum > 32767 -> 16'h7FFF, sum < -32768 -> 16'h8000, else low 16 bits.
REQ-025 Latency in_valid&in_ready -> out_valid SHALL be exactly 2 cycles with out_ready held high; throughput one vector per cycle.
REQ-026 When stall is high, both stages and their valid bits SHALL hold; bias_data and calculate_en SHALL stay stable while out_valid and not out_ready.
REQ-027 Stage 1 and stage 2 valids SHALL advance (bubbles collapse only through normal flow; no bubble squashing required).
REQ-028 bias register contents SHALL persist across vectors until the next complete LOAD.

Reset
REQ-029 On rst_n low at a clock edge: state=IDLE, beat_cnt=0, stage valids=0, out_valid=0, bias_data=0, calculate_en=0, bias_loaded=0, in_ready=0, bias register=0.
REQ-030 Reset mid-LOAD or with data in flight SHALL discard partial bias and in-flight vectors; no output emitted afterwards until a new LOAD completes.

Structure
REQ-031 LANES, DW, BEATS, beat width 128 and the FSM state enum SHALL live in shared package npu_pkg.
REQ-032 Per-lane add-and-saturate SHALL be sub-module bias_add_lane, instantiated LANES times via generate.

Verification
REQ-033 Load beats 0x0001 repeated in all lanes (4 beats) -> bias_loaded high the cycle after 4th beat; in_data all lanes 0x0005 -> bias_data all 0x0006 two cycles later.
REQ-034 Bias 0x7FF0, input 0x0020 -> 0x7FFF; bias 0x8010, input 0xFFE0 -> 0x8000; bias 0xFFFF, input 0x0001 -> 0x0000.
REQ-035 Stream 8 back-to-back vectors, out_ready low for 3 cycles mid-stream -> in_ready low during stall, no loss/duplication, order preserved, bias_data stable while stalled.
REQ-036 in_relu_en pattern 1,0,1 on consecutive vectors -> calculate_en 1,0,1 aligned with corresponding bias_data.
REQ-037 bias_load_en in RUN with vectors in flight -> ignored; after drain, reload with 0x0002 -> subsequent outputs use new bias.
REQ-038 rst_n low after 2 of 4 beats -> all outputs 0, state IDLE; in_valid then held high -> in_ready stays 0, no out_valid.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU constants and types.
// Lane geometry, bias beat width and bias-add FSM states.
package npu_pkg;

  localparam int LANES  = 32;
  localparam int DW     = 16;
  localparam int BEATS  = 4;
  localparam int BEAT_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/bias_add_if.sv
// Bias-add bus: bias load, partial-sum
// input stream and saturated output stream.
interface bias_add_if #(
  parameter int LANES = npu_pkg::LANES,
  parameter int DW    = npu_pkg::DW,
  parameter int BW    = npu_pkg::BEAT_W
);

  logic                bias_load_en;
  logic                bias_wr_valid;
  logic [BW-1:0]       bias_wr_data;
  logic                bias_loaded;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data;
  logic                in_relu_en;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*DW-1:0] bias_data;
  logic                calculate_en;

  modport master (
    output bias_load_en,
    output bias_wr_valid,
    output bias_wr_data,
    output in_valid,
    output in_data,
    output in_relu_en,
    output out_ready,
    input  bias_loaded,
    input  in_ready,
    input  out_valid,
    input  bias_data,
    input  calculate_en
  );

  modport slave (
    input  bias_load_en,
    input  bias_wr_valid,
    input  bias_wr_data,
    input  in_valid,
    input  in_data,
    input  in_relu_en,
    input  out_ready,
    output bias_loaded,
    output in_ready,
    output out_valid,
    output bias_data,
    output calculate_en
  );

endinterface

// File: rtl/bias_add_lane.sv
// One lane: registered 17-bit sum, then
// registered saturation back to DW bits.
module bias_add_lane #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          s1_ld_i,
  input  logic          s2_ld_i,
  input  logic [DW-1:0] in_i,
  input  logic [DW-1:0] bias_i,
  output logic [DW-1:0] out_o
);

  localparam logic [DW-1:0] MAXV =
    {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINV =
    {1'b1, {(DW-1){1'b0}}};

  logic [DW:0]   sum_q, sum_d;
  logic [DW-1:0] sat_q, sat_d;

  always_comb begin
    sum_d = {in_i[DW-1], in_i}
          + {bias_i[DW-1], bias_i};
  end

  // top two bits disagree only on overflow
  always_comb begin
    sat_d = sum_q[DW-1:0];
    unique case (1'b1)
      (sum_q[DW] & ~sum_q[DW-1]): sat_d = MINV;
      (~sum_q[DW] & sum_q[DW-1]): sat_d = MAXV;
      default:                    sat_d = sum_q[DW-1:0];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q <= '0;
      sat_q <= '0;
    end else begin
      if (s1_ld_i) sum_q <= sum_d;
      if (s2_ld_i) sat_q <= sat_d;
    end
  end

  assign out_o = sat_q;

endmodule

// File: rtl/bias_add.sv
// Bias add: beat-wise bias load, then a
// two-stage add/saturate pipeline per lane.
module bias_add #(
  parameter int LANES = npu_pkg::LANES,
  parameter int DW    = npu_pkg::DW,
  parameter int BEATS = npu_pkg::BEATS
) (
  input  logic       clk,
  input  logic       rst_n,
  bias_add_if.slave  bus
);

  import npu_pkg::*;

  localparam int BW = BEAT_W;
  localparam int CW =
    (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LANES*DW-1:0] bias_q;
  logic [LANES*DW-1:0] bdata;

  logic s1_v_q, s1_v_d;
  logic s1_r_q, s1_r_d;
  logic s2_v_q, s2_v_d;
  logic s2_r_q, s2_r_d;

  logic run, wr_en, stall;
  logic acc, s1_ld, s2_ld;
  logic empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    empty   = ~s1_v_q & ~s2_v_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.bias_load_en)
          state_d = LOAD;
      end
      LOAD: begin
        if (bus.bias_wr_valid) begin
          if (cnt_q == CW'(BEATS-1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.bias_load_en && empty)
          state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run   = (state_q == RUN);
    wr_en = (state_q == LOAD)
          & bus.bias_wr_valid;
    stall = s2_v_q & ~bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      bias_q <= '0;
    else if (wr_en)
      bias_q[int'(cnt_q)*BW +: BW]
        <= bus.bias_wr_data;
  end

  // a stall freezes both stages together
  always_comb begin
    acc    = bus.in_valid & run & ~stall;
    s1_ld  = acc;
    s2_ld  = ~stall & s1_v_q;
    s1_v_d = stall ? s1_v_q : acc;
    s2_v_d = stall ? s2_v_q : s1_v_q;
    s1_r_d = s1_ld ? bus.in_relu_en
                   : s1_r_q;
    s2_r_d = s2_ld ? s1_r_q : s2_r_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_r_q <= 1'b0;
      s2_v_q <= 1'b0;
      s2_r_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_r_q <= s1_r_d;
      s2_v_q <= s2_v_d;
      s2_r_q <= s2_r_d;
    end
  end

  for (genvar i = 0; i < LANES; i++)
  begin : g_lane
    bias_add_lane #(.DW(DW)) u_lane (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .s1_ld_i (s1_ld),
      .s2_ld_i (s2_ld),
      .in_i    (bus.in_data[i*DW +: DW]),
      .bias_i  (bias_q[i*DW +: DW]),
      .out_o   (bdata[i*DW +: DW])
    );
  end

  assign bus.bias_loaded  = run;
  assign bus.in_ready     = run & ~stall;
  assign bus.out_valid    = s2_v_q;
  assign bus.calculate_en = s2_r_q;
  assign bus.bias_data    = bdata;

endmodule
